// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_pkg
//  Purpose  : Shared descriptor layouts and field widths for the sprite
//             display path (address calculators and the display block).
//  Revision : 1.0 - initial release
// ============================================================================
package sprite_pkg;

  localparam int ADDR_W  = 16;
  localparam int COORD_W = 10;

  // Pattern descriptor, MSB first: base, width, height, stride, reserved
  typedef struct packed {
    logic [ADDR_W-1:0] base_addr;
    logic [15:0]       width;
    logic [15:0]       height;
    logic [15:0]       row_stride;
    logic [15:0]       reserved;
  } pattern_info_t;

  // Sprite placement, MSB first: visible, flip, x, y, reserved
  typedef struct packed {
    logic               visible;
    logic               flip;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [9:0]         reserved;
  } sprite_info_t;

endpackage : sprite_pkg
`default_nettype wire

// File: rtl/sprite_addr_cal.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_addr_cal
//  Purpose  : Per-sprite inside test and texel address generation. One
//             registered stage: outputs reflect inputs sampled at the
//             previous rising clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_addr_cal
  import sprite_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [79:0] pattern_info,
  input  logic [31:0] sprite_info,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [15:0] addr_output,
  output logic        valid
);

  pattern_info_t      pat_w;
  sprite_info_t       spr_w;
  logic [16:0]        x_end_w;
  logic [16:0]        y_end_w;
  logic               inside_w;
  logic [COORD_W-1:0] col_w;
  logic [COORD_W-1:0] row_w;
  logic [15:0]        col_eff_w;
  logic [31:0]        prod_w;
  logic [31:0]        sum_w;
  logic [ADDR_W-1:0]  addr_d;
  logic               valid_d;
  logic [ADDR_W-1:0]  addr_q;
  logic               valid_q;
  logic               unused_bits_w;

  // Inside test and texel address, fully combinational from the inputs
  always_comb begin
    pat_w     = pattern_info_t'(pattern_info);
    spr_w     = sprite_info_t'(sprite_info);

    // 17-bit ends so a sprite running past column/row 1023 does not wrap
    x_end_w   = {7'd0, spr_w.x} + {1'b0, pat_w.width};
    y_end_w   = {7'd0, spr_w.y} + {1'b0, pat_w.height};

    // Zero width/height yields an empty range, so never inside
    inside_w  = spr_w.visible &&
                (hcount >= spr_w.x) && ({7'd0, hcount} < x_end_w) &&
                (vcount >= spr_w.y) && ({7'd0, vcount} < y_end_w);

    col_w     = hcount - spr_w.x;
    row_w     = vcount - spr_w.y;

    col_eff_w = spr_w.flip ? (pat_w.width - 16'd1 - {6'd0, col_w})
                           : {6'd0, col_w};

    // Wide arithmetic, truncated afterwards: address wraps modulo 2^16
    prod_w    = {22'd0, row_w} * {16'd0, pat_w.row_stride};
    sum_w     = {16'd0, pat_w.base_addr} + prod_w + {16'd0, col_eff_w};

    valid_d   = inside_w;
    addr_d    = inside_w ? sum_w[ADDR_W-1:0] : '0;
  end

  // Bits intentionally dropped: reserved fields and the high address bits
  assign unused_bits_w = ^{pat_w.reserved, spr_w.reserved, sum_w[31:ADDR_W]};

  // Output registers; reset clears them immediately, independent of clk
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  assign addr_output = addr_q;
  assign valid       = valid_q;

endmodule : sprite_addr_cal
`default_nettype wire

// File: tb/tb_sprite_addr_cal.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_addr_cal
//  Purpose  : Directed, self-checking bench for sprite_addr_cal with
//             hand-computed expected texel addresses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_addr_cal;

  logic        clk;
  logic        reset;
  logic [79:0] pattern_info;
  logic [31:0] sprite_info;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [15:0] addr_output;
  logic        valid;

  int n_checks;
  int n_pass;

  sprite_addr_cal dut (
    .clk          (clk),
    .reset        (reset),
    .pattern_info (pattern_info),
    .sprite_info  (sprite_info),
    .hcount       (hcount),
    .vcount       (vcount),
    .addr_output  (addr_output),
    .valid        (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reserved fields carry junk so that ignoring them is exercised too
  function automatic logic [79:0] mk_pat(input logic [15:0] base, input logic [15:0] w,
                                         input logic [15:0] h, input logic [15:0] stride);
    return {base, w, h, stride, 16'hBEEF};
  endfunction

  function automatic logic [31:0] mk_spr(input logic vis, input logic flip,
                                         input logic [9:0] x, input logic [9:0] y);
    return {vis, flip, x, y, 10'h3A5};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Drive a raster position, let one edge pass, sample 1 ns later
  task automatic step(input logic [9:0] h, input logic [9:0] v);
    hcount = h;
    vcount = v;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic exp_v, input logic [15:0] exp_a);
    check({tag, ".valid"}, {31'd0, valid}, {31'd0, exp_v});
    check({tag, ".addr"},  {16'd0, addr_output}, {16'd0, exp_a});
  endtask

  task automatic defaults();
    pattern_info = mk_pat(16'd0, 16'd16, 16'd16, 16'd16);
    sprite_info  = mk_spr(1'b1, 1'b0, 10'd100, 10'd50);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    defaults();
    hcount   = 10'd100;
    vcount   = 10'd50;

    // Reset state, even with a hit presented and clocks running
    @(posedge clk); #1;
    @(posedge clk); #1;
    expect_out("reset", 1'b0, 16'd0);
    reset = 1'b0;

    // Inside geometry and boundaries
    step(10'd100, 10'd50); expect_out("origin", 1'b1, 16'd0);
    step(10'd115, 10'd65); expect_out("far_corner", 1'b1, 16'd255);
    step(10'd116, 10'd65); expect_out("right_out", 1'b0, 16'd0);
    step(10'd115, 10'd66); expect_out("bottom_out", 1'b0, 16'd0);
    step(10'd99,  10'd50); expect_out("left_out", 1'b0, 16'd0);
    step(10'd100, 10'd49); expect_out("top_out", 1'b0, 16'd0);

    // Horizontal mirror
    sprite_info = mk_spr(1'b1, 1'b1, 10'd100, 10'd50);
    step(10'd100, 10'd50); expect_out("flip_origin", 1'b1, 16'd15);
    step(10'd115, 10'd51); expect_out("flip_row1", 1'b1, 16'd16);

    // Base offset, then hidden sprite at the same spot
    defaults();
    pattern_info = mk_pat(16'd256, 16'd16, 16'd16, 16'd16);
    step(10'd103, 10'd52); expect_out("base_off", 1'b1, 16'd291);
    sprite_info = mk_spr(1'b0, 1'b0, 10'd100, 10'd50);
    step(10'd103, 10'd52); expect_out("invisible", 1'b0, 16'd0);

    // Zero width never hits
    defaults();
    pattern_info = mk_pat(16'd0, 16'd0, 16'd16, 16'd16);
    step(10'd100, 10'd50); expect_out("zero_width", 1'b0, 16'd0);

    // Sprite clipped by the raster edge: x+width > 1023 must not wrap
    pattern_info = mk_pat(16'd0, 16'd16, 16'd16, 16'd16);
    sprite_info  = mk_spr(1'b1, 1'b0, 10'd1020, 10'd50);
    step(10'd1023, 10'd50); expect_out("clip_edge", 1'b1, 16'd3);
    step(10'd2,    10'd50); expect_out("clip_nowrap", 1'b0, 16'd0);

    // Address wraps modulo 2^16; descriptor change lands with hcount
    defaults();
    pattern_info = mk_pat(16'hFFFF, 16'd16, 16'd16, 16'd16);
    step(10'd101, 10'd50); expect_out("addr_wrap", 1'b1, 16'd0);

    // Different stride: row 3 * 40 + col 7 = 127
    pattern_info = mk_pat(16'd0, 16'd16, 16'd16, 16'd40);
    step(10'd107, 10'd53); expect_out("stride40", 1'b1, 16'd127);

    // Latency sweep: output follows each new hcount one edge later
    defaults();
    for (int i = 0; i < 4; i++) begin
      step(10'd100 + 10'(i), 10'd50);
      expect_out("sweep", 1'b1, 16'(i));
    end
    hcount = 10'd110;
    #3;
    expect_out("hold_between_edges", 1'b1, 16'd3);
    @(posedge clk); #1;
    expect_out("next_edge", 1'b1, 16'd10);

    // Asynchronous reset between edges, held across an edge, then release
    step(10'd105, 10'd55); expect_out("pre_reset", 1'b1, 16'd85);
    #2;
    reset = 1'b1;
    #1;
    expect_out("async_reset", 1'b0, 16'd0);
    @(posedge clk); #1;
    expect_out("reset_held", 1'b0, 16'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    expect_out("post_reset", 1'b1, 16'd85);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_sprite_addr_cal
`default_nettype wire
